// File: rtl/aurora_hls_pkg.sv
// Shared definitions for the Aurora link bring-up sequencer.
package aurora_hls_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReset   = 3'd1,
    StWaitUp  = 3'd2,
    StStable  = 3'd3,
    StUp      = 3'd4,
    StBackoff = 3'd5,
    StFault   = 3'd6
  } link_state_e;

  // All lanes up plus channel up.
  localparam logic [12:0] STATUS_OK_DEFAULT = 13'h11ff;

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/aurora_hls_link_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module aurora_hls_link_timer #(
  parameter int unsigned Width = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             done
);

  logic [Width-1:0] count_q;

  // Load wins over counting; the count holds at zero once expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/aurora_hls_link_ctrl.sv
// Aurora core bring-up / recovery sequencer with bounded retries.
module aurora_hls_link_ctrl
  import aurora_hls_pkg::*;
#(
  parameter logic [12:0] STATUS_OK      = STATUS_OK_DEFAULT,
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned UP_TIMEOUT     = 1024,
  parameter int unsigned STABLE_CYCLES  = 32,
  parameter int unsigned BACKOFF_CYCLES = 64,
  parameter int unsigned MAX_RETRIES    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_fault,
  input  logic [12:0] aurora_status,
  input  logic        fifo_tx_almost_full,
  output logic        aurora_reset,
  output logic        link_ready,
  output logic        tx_enable,
  output logic        fault,
  output logic [7:0]  retry_count,
  output logic [31:0] link_drop_count,
  output logic [2:0]  state
);

  localparam int unsigned MaxDur =
      max_of4(RESET_CYCLES, UP_TIMEOUT, STABLE_CYCLES, BACKOFF_CYCLES);
  localparam int unsigned TimerW = $clog2(MaxDur) + 1;

  // Timer is loaded with N-1 so the exit happens on the N-th edge in the state.
  localparam logic [TimerW-1:0] ResetLoad   = TimerW'(RESET_CYCLES - 1);
  localparam logic [TimerW-1:0] UpLoad      = TimerW'(UP_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLoad  = TimerW'(STABLE_CYCLES - 1);
  localparam logic [TimerW-1:0] BackoffLoad = TimerW'(BACKOFF_CYCLES - 1);
  localparam logic [7:0]        MaxRetries  = 8'(MAX_RETRIES);

  link_state_e       state_q, state_d;
  logic [7:0]        retry_q, retry_d;
  logic [31:0]       drop_q, drop_d;
  logic              aurora_reset_q, link_ready_q, fault_q, tx_enable_q;
  logic              status_ok;
  logic              timer_done;
  logic              timer_load;
  logic [TimerW-1:0] timer_value;

  assign status_ok = (aurora_status == STATUS_OK);

  // Next-state, retry and drop-count logic; enable=0 overrides everything.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    drop_d  = drop_q;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StReset;
      end
      StReset: begin
        if (timer_done) state_d = StWaitUp;
      end
      StWaitUp: begin
        if (status_ok) begin
          state_d = StStable;
        end else if (timer_done) begin
          if (retry_q < MaxRetries) begin
            retry_d = retry_q + 8'd1;
            state_d = StBackoff;
          end else begin
            state_d = StFault;
          end
        end
      end
      StStable: begin
        if (!status_ok) begin
          state_d = StWaitUp;
        end else if (timer_done) begin
          state_d = StUp;
          retry_d = '0;
        end
      end
      StUp: begin
        if (!status_ok) begin
          state_d = StReset;
          if (drop_q != 32'hFFFF_FFFF) drop_d = drop_q + 32'd1;
        end
      end
      StBackoff: begin
        if (timer_done) state_d = StReset;
      end
      StFault: begin
        if (clear_fault) begin
          state_d = StIdle;
          retry_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!enable && (state_q != StIdle)) begin
      state_d = StIdle;
      retry_d = retry_q;
      drop_d  = drop_q;
    end
  end

  // Reload the shared timer on every state entry with the entered state's duration.
  always_comb begin
    timer_load  = (state_d != state_q);
    timer_value = '0;
    case (state_d)
      StReset:   timer_value = ResetLoad;
      StWaitUp:  timer_value = UpLoad;
      StStable:  timer_value = StableLoad;
      StBackoff: timer_value = BackoffLoad;
      default:   timer_value = '0;
    endcase
  end

  aurora_hls_link_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // State register plus outputs decoded from the next state so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      retry_q        <= '0;
      drop_q         <= '0;
      aurora_reset_q <= 1'b1;
      link_ready_q   <= 1'b0;
      fault_q        <= 1'b0;
      tx_enable_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      retry_q        <= retry_d;
      drop_q         <= drop_d;
      aurora_reset_q <= !((state_d == StWaitUp) || (state_d == StStable) || (state_d == StUp));
      link_ready_q   <= (state_d == StUp);
      fault_q        <= (state_d == StFault);
      // Built from the current state, so it trails link_ready by one cycle.
      tx_enable_q    <= (state_q == StUp) && !fifo_tx_almost_full;
    end
  end

  assign state           = state_q;
  assign aurora_reset    = aurora_reset_q;
  assign link_ready      = link_ready_q;
  assign fault           = fault_q;
  assign tx_enable       = tx_enable_q;
  assign retry_count     = retry_q;
  assign link_drop_count = drop_q;

endmodule
